// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: default operand width and the 5-bit
// opcode encoding used by the decoder and by any block that issues opcodes.
package alu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int OPC_W      = 5;

   typedef enum logic [OPC_W-1:0] {
      OP_LD   = 5'b00000,
      OP_LDI  = 5'b00001,
      OP_ST   = 5'b00010,
      OP_ADD  = 5'b00011,
      OP_SUB  = 5'b00100,
      OP_AND  = 5'b00101,
      OP_OR   = 5'b00110,
      OP_ROR  = 5'b00111,
      OP_ROL  = 5'b01000,
      OP_SHR  = 5'b01001,
      OP_SHRA = 5'b01010,
      OP_SHL  = 5'b01011,
      OP_ADDI = 5'b01100,
      OP_ANDI = 5'b01101,
      OP_ORI  = 5'b01110,
      OP_MUL  = 5'b01111,
      OP_DIV  = 5'b10000,
      OP_NEG  = 5'b10001,
      OP_NOT  = 5'b10010
   } opcode_e;

endpackage

// File: rtl/booth_mul.sv
// Combinational radix-4 Booth signed multiplier, DATA_W x DATA_W -> 2*DATA_W.
// DATA_W must be even so the multiplier splits into whole Booth digits.
module booth_mul
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0]   multiplicand_i,
   input  logic [DATA_W-1:0]   multiplier_i,
   output logic [2*DATA_W-1:0] product_o
);

   localparam int DIGITS = DATA_W / 2;

   logic signed [2*DATA_W-1:0] a_ext;
   logic signed [2*DATA_W-1:0] pp;
   logic signed [2*DATA_W-1:0] acc;
   logic        [DATA_W:0]     b_ext;

   // Recode the multiplier into digits in {-2..+2} and sum the shifted partial products
   always_comb begin
      a_ext = {{DATA_W{multiplicand_i[DATA_W-1]}}, multiplicand_i};
      b_ext = {multiplier_i, 1'b0};
      pp    = '0;
      acc   = '0;
      for (int i = 0; i < DIGITS; i++) begin
         case (b_ext[2*i+2 -: 3])
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext <<< 1;
            3'b100:         pp = -(a_ext <<< 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
         endcase
         acc = acc + (pp <<< (2*i));
      end
      product_o = acc;
   end

endmodule

// File: rtl/alu.sv
// Single-cycle ALU with registered 2*DATA_W result: {HI, LO}.
// HI carries the upper product half for mul and the remainder for div,
// and is zero for every other operation.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                IncPC,
   input  logic [DATA_W-1:0]   input_a,
   input  logic [DATA_W-1:0]   input_b,
   input  logic [OPC_W-1:0]    opcode,
   output logic [2*DATA_W-1:0] ALU_result
);

   localparam int              SH_W = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

   logic [2*DATA_W-1:0] result_q, result_d;
   logic [2*DATA_W-1:0] product;
   logic [2*DATA_W-1:0] rot_r, rot_l;
   logic [SH_W-1:0]     shamt;
   logic [DATA_W-1:0]   hi, lo;

   logic                a_neg, b_neg;
   logic [DATA_W-1:0]   a_mag, b_mag, b_div;
   logic [DATA_W-1:0]   q_mag, r_mag, quot, rem;

   booth_mul #(.DATA_W(DATA_W)) u_booth_mul (
      .multiplicand_i (input_a),
      .multiplier_i   (input_b),
      .product_o      (product)
   );

   // Rotates read one word out of a doubled copy of A, so amount 0 returns A
   always_comb begin
      shamt = input_b[SH_W-1:0];
      rot_r = {input_a, input_a} >> shamt;
      rot_l = {input_a, input_a} << shamt;
   end

   // Signed divide on magnitudes: quotient truncates toward zero, remainder
   // follows the dividend; MIN / -1 falls out as MIN with remainder 0
   always_comb begin
      a_neg = input_a[DATA_W-1];
      b_neg = input_b[DATA_W-1];
      a_mag = a_neg ? (~input_a + ONE) : input_a;
      b_mag = b_neg ? (~input_b + ONE) : input_b;
      b_div = (b_mag == '0) ? ONE : b_mag;
      q_mag = a_mag / b_div;
      r_mag = a_mag % b_div;
      quot  = (a_neg ^ b_neg) ? (~q_mag + ONE) : q_mag;
      rem   = a_neg ? (~r_mag + ONE) : r_mag;
   end

   // Opcode decode; IncPC overrides everything with B+1
   always_comb begin
      hi = '0;
      lo = '0;
      if (IncPC) begin
         lo = input_b + ONE;
      end else begin
         case (opcode)
            OP_LD, OP_LDI, OP_ST,
            OP_ADD, OP_ADDI: lo = input_a + input_b;
            OP_SUB:          lo = input_a - input_b;
            OP_AND, OP_ANDI: lo = input_a & input_b;
            OP_OR,  OP_ORI:  lo = input_a | input_b;
            OP_ROR:          lo = rot_r[DATA_W-1:0];
            OP_ROL:          lo = rot_l[2*DATA_W-1:DATA_W];
            OP_SHR:          lo = input_a >> shamt;
            OP_SHRA:         lo = $signed(input_a) >>> shamt;
            OP_SHL:          lo = input_a << shamt;
            OP_MUL:          {hi, lo} = product;
            OP_DIV: begin
               if (input_b == '0) begin
                  hi = input_a;
                  lo = '1;
               end else begin
                  hi = rem;
                  lo = quot;
               end
            end
            OP_NEG:          lo = ~input_a + ONE;
            OP_NOT:          lo = ~input_a;
            default: begin
               hi = '0;
               lo = '0;
            end
         endcase
      end
      result_d = {hi, lo};
   end

   // Result register; clr clears it at once and holds it clear
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         result_q <= '0;
      end else begin
         result_q <= result_d;
      end
   end

   assign ALU_result = result_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the ALU: the driver pushes expected results into a
// queue, the monitor pops one after every rising edge that follows a push.
module tb_alu;

   logic        clk;
   logic        clr;
   logic        IncPC;
   logic [31:0] input_a;
   logic [31:0] input_b;
   logic [4:0]  opcode;
   logic [63:0] ALU_result;

   typedef struct {
      logic [63:0] exp;
      string       name;
   } sb_item_t;

   sb_item_t sb_q[$];
   sb_item_t mon_item;
   int       checks = 0;
   int       fails  = 0;

   alu #(.DATA_W(32)) dut (
      .clk        (clk),
      .clr        (clr),
      .IncPC      (IncPC),
      .input_a    (input_a),
      .input_b    (input_b),
      .opcode     (opcode),
      .ALU_result (ALU_result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model written from the operation definitions
   function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] op, input logic inc);
      int          sa;
      int          sb;
      int unsigned sh;
      logic [31:0] hi;
      logic [31:0] lo;
      longint      p;
      sa = a;
      sb = b;
      sh = {27'd0, b[4:0]};
      hi = 32'd0;
      lo = 32'd0;
      if (inc) return {32'd0, b + 32'd1};
      case (op)
         5'd0, 5'd1, 5'd2, 5'd3, 5'd12: lo = a + b;
         5'd4:          lo = a - b;
         5'd5, 5'd13:   lo = a & b;
         5'd6, 5'd14:   lo = a | b;
         5'd7: begin
            lo = a;
            repeat (sh) lo = {lo[0], lo[31:1]};
         end
         5'd8: begin
            lo = a;
            repeat (sh) lo = {lo[30:0], lo[31]};
         end
         5'd9:          lo = a >> sh;
         5'd10:         lo = sa >>> sh;
         5'd11:         lo = a << sh;
         5'd15: begin
            p = longint'(sa) * longint'(sb);
            {hi, lo} = p;
         end
         5'd16: begin
            if (sb == 0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else if (a == 32'h8000_0000 && sb == -1) begin
               lo = 32'h8000_0000;
               hi = 32'd0;
            end else begin
               lo = sa / sb;
               hi = sa % sb;
            end
         end
         5'd17:         lo = -sa;
         5'd18:         lo = ~a;
         default:       lo = 32'd0;
      endcase
      return {hi, lo};
   endfunction

   task automatic drive_exp(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                            input logic inc, input string name, input logic [63:0] exp);
      sb_item_t it;
      input_a = a;
      input_b = b;
      opcode  = op;
      IncPC   = inc;
      it.exp  = exp;
      it.name = name;
      sb_q.push_back(it);
   endtask

   task automatic drive_model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                              input logic inc, input string name);
      drive_exp(a, b, op, inc, name, ref_alu(a, b, op, inc));
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] specials [6];
      specials[0] = 32'h0000_0000;
      specials[1] = 32'h0000_0001;
      specials[2] = 32'hFFFF_FFFF;
      specials[3] = 32'h8000_0000;
      specials[4] = 32'h7FFF_FFFF;
      specials[5] = 32'h0000_0002;
      if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
      if ($urandom_range(3) == 0) return $urandom_range(40) - 20;
      return $urandom;
   endfunction

   task automatic check_now(input string name, input logic [63:0] exp);
      checks++;
      if (ALU_result !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, ALU_result, exp);
      end
   endtask

   // Monitor: one result per rising edge while expectations are queued
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            mon_item = sb_q.pop_front();
            checks++;
            if (ALU_result !== mon_item.exp) begin
               fails++;
               $display("FAIL %s: got %h expected %h", mon_item.name, ALU_result, mon_item.exp);
            end
         end
      end
   end

   // Stimulus
   initial begin
      clr     = 1'b1;
      IncPC   = 1'b0;
      input_a = 32'd0;
      input_b = 32'd0;
      opcode  = 5'd0;
      #3;
      clr = 1'b0;
      #1;
      check_now("reset_async", 64'd0);

      // held in reset across an edge with a nonzero pending result
      @(negedge clk);
      drive_exp(32'd5, 32'd5, 5'b00011, 1'b0, "reset_hold", 64'd0);
      @(negedge clk);
      clr = 1'b1;

      drive_exp(32'hFFFF_FD12, 32'd10,         5'b01111, 1'b0, "mul_neg750x10", 64'hFFFF_FFFF_FFFF_E2B4);
      @(negedge clk);
      drive_exp(32'hFFFF_FFF9, 32'd2,          5'b10000, 1'b0, "div_m7_2",      64'hFFFF_FFFF_FFFF_FFFD);
      @(negedge clk);
      drive_exp(32'hFFFF_FFF9, 32'd0,          5'b10000, 1'b0, "div_by_zero",   64'hFFFF_FFF9_FFFF_FFFF);
      @(negedge clk);
      drive_exp(32'h8000_0000, 32'hFFFF_FFFF,  5'b10000, 1'b0, "div_min_m1",    64'h0000_0000_8000_0000);
      @(negedge clk);
      drive_exp(32'd7,         32'hFFFF_FFFE,  5'b10000, 1'b0, "div_7_m2",      64'h0000_0001_FFFF_FFFD);
      @(negedge clk);
      drive_exp(32'h8000_0001, 32'd1,          5'b01010, 1'b0, "shra",          64'h0000_0000_C000_0000);
      @(negedge clk);
      drive_exp(32'h8000_0001, 32'd1,          5'b01001, 1'b0, "shr",           64'h0000_0000_4000_0000);
      @(negedge clk);
      drive_exp(32'h8000_0001, 32'd1,          5'b00111, 1'b0, "ror",           64'h0000_0000_C000_0000);
      @(negedge clk);
      drive_exp(32'h8000_0001, 32'd1,          5'b01000, 1'b0, "rol",           64'h0000_0000_0000_0003);
      @(negedge clk);
      drive_exp(32'h8000_0001, 32'h0000_0020,  5'b01010, 1'b0, "shra_amt0",     64'h0000_0000_8000_0001);
      @(negedge clk);
      drive_exp(32'h7FFF_FFFF, 32'd1,          5'b00011, 1'b0, "add_wrap",      64'h0000_0000_8000_0000);
      @(negedge clk);
      drive_exp(32'd0,         32'd1,          5'b00100, 1'b0, "sub_wrap",      64'h0000_0000_FFFF_FFFF);
      @(negedge clk);
      drive_exp(32'd0,         32'h0000_0010,  5'b01111, 1'b1, "incpc",         64'h0000_0000_0000_0011);
      @(negedge clk);
      drive_exp(32'h8000_0000, 32'd0,          5'b10001, 1'b0, "neg_min",       64'h0000_0000_8000_0000);
      @(negedge clk);
      drive_exp(32'h0F0F_0F0F, 32'd0,          5'b10010, 1'b0, "not",           64'h0000_0000_F0F0_F0F0);
      @(negedge clk);
      drive_exp(32'h1234_5678, 32'h1111_1111,  5'b10011, 1'b0, "undef_op",      64'd0);
      @(negedge clk);
      drive_exp(32'h0000_0100, 32'h0000_0020,  5'b00000, 1'b0, "ld_addr",       64'h0000_0000_0000_0120);

      // async clear between edges discards the held result
      @(negedge clk);
      drive_exp(32'd3, 32'd4, 5'b00011, 1'b0, "pre_clr", 64'h0000_0000_0000_0007);
      @(posedge clk);
      #3;
      clr = 1'b0;
      #1;
      check_now("clr_mid_cycle", 64'd0);
      @(negedge clk);
      drive_exp(32'd3, 32'd4, 5'b00011, 1'b0, "clr_held", 64'd0);
      @(negedge clk);
      clr = 1'b1;
      drive_model(32'd3, 32'd4, 5'b00011, 1'b0, "post_clr");

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         drive_model(pick_operand(), pick_operand(), 5'($urandom_range(31)),
                     ($urandom_range(7) == 0), "random");
      end

      // drain with a bounded wait
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() > 0) begin
         checks++;
         fails++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
